// File: rtl/timekeeper_pkg.sv
// Shared constants for the time-of-day core: set-mode encodings, field limits and widths,
// plus a wrap-around step helper used by both the tick path and the set-mode edits.
package timekeeper_pkg;
  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  // +1/-1 on a field that wraps between 0 and max_v.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) begin
      return (v == max_v) ? 6'd0 : v + 6'd1;
    end
    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction
endpackage

// File: rtl/tk_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles; clear forces the count
// back to zero so the next second starts full-length.
module tk_prescaler #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/timekeeper_core.sv
// hh:mm:ss time-of-day counter with 1 Hz prescaler and set-mode FSM (RUN/SET_HOUR/SET_MIN/SET_SEC).
// Optional alarm comparator enabled by defining TK_ALARM_EN.
module timekeeper_core
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ    = 1000,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              op1,
  input  logic              op2,
  input  logic [4:0]        alarm_hours,
  input  logic [5:0]        alarm_minutes,
  input  logic              alarm_en,
  input  logic              alarm_ack,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic [3:0]        hours12,
  output logic              is_pm,
  output logic [1:0]        set_mode,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              alarm
);
  logic       in_run;
  logic       tick;
  logic [5:0] sec_up, sec_dn, min_up, min_dn, hour_up6, hour_dn6;
  logic       sec_carry, min_carry, hour_carry;
  logic       edit_en;

  assign in_run = (set_mode == MODE_RUN);

  // Holding clear for the whole of set mode means RUN always restarts from a zero count.
  tk_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (in_run),
    .clear  (!in_run),
    .tick   (tick)
  );

  assign sec_up     = wrap_step(seconds, SEC_MAX, 1'b1);
  assign sec_dn     = wrap_step(seconds, SEC_MAX, 1'b0);
  assign min_up     = wrap_step(minutes, MIN_MAX, 1'b1);
  assign min_dn     = wrap_step(minutes, MIN_MAX, 1'b0);
  assign hour_up6   = wrap_step({1'b0, hours}, {1'b0, HOUR_MAX}, 1'b1);
  assign hour_dn6   = wrap_step({1'b0, hours}, {1'b0, HOUR_MAX}, 1'b0);
  assign sec_carry  = (seconds == SEC_MAX);
  assign min_carry  = (minutes == MIN_MAX);
  assign hour_carry = (hours == HOUR_MAX);

  // A set press takes priority over op1/op2, and op1 with op2 cancels out.
  assign edit_en = !in_run && !set && (op1 ^ op2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seconds  <= '0;
      minutes  <= MIN_W'(INIT_MIN);
      hours    <= HOUR_W'(INIT_HOUR);
      set_mode <= MODE_RUN;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= tick;
      day_wrap <= tick && sec_carry && min_carry && hour_carry;
      if (tick) begin
        seconds <= sec_up;
        if (sec_carry) begin
          minutes <= min_up;
          if (min_carry) hours <= hour_up6[4:0];
        end
      end else if (edit_en) begin
        case (set_mode)
          MODE_SET_HOUR: hours   <= op1 ? hour_up6[4:0] : hour_dn6[4:0];
          MODE_SET_MIN:  minutes <= op1 ? min_up : min_dn;
          MODE_SET_SEC:  seconds <= op1 ? sec_up : sec_dn;
          default:       ;
        endcase
      end
      if (set) set_mode <= set_mode + 2'd1;
    end
  end

  assign is_pm   = (hours >= 5'd12);
  assign hours12 = (hours == 5'd0) ? 4'd12 :
                   (hours > 5'd12) ? 4'(hours - 5'd12) : hours[3:0];

`ifdef TK_ALARM_EN
  logic alarm_hit;

  // Only a running tick can land on the alarm time, so set-mode edits never trigger it.
  assign alarm_hit = tick && sec_carry && (minutes == MIN_MAX ? min_up : minutes) == alarm_minutes
                     && ((sec_carry && min_carry) ? hour_up6[4:0] : hours) == alarm_hours;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (alarm_ack || !alarm_en) begin
      alarm <= 1'b0;
    end else if (alarm_hit) begin
      alarm <= 1'b1;
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hours, alarm_minutes, alarm_en, alarm_ack};
  assign alarm        = 1'b0;
`endif
endmodule

// File: tb/tb_timekeeper_core.sv
// Scoreboard bench for timekeeper_core: a seconds-of-day reference model predicts every cycle,
// a monitor compares each cycle's outputs. Alarm checks follow TK_ALARM_EN.
module tb_timekeeper_core;
  localparam int HZ    = 4;
  localparam int IH    = 0;
  localparam int IM    = 0;
  localparam int DAY   = 86400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set = 1'b0, op1 = 1'b0, op2 = 1'b0;
  logic [4:0] alarm_hours = '0;
  logic [5:0] alarm_minutes = '0;
  logic       alarm_en = 1'b0, alarm_ack = 1'b0;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [3:0] hours12;
  logic       is_pm, sec_tick, day_wrap, alarm;
  logic [1:0] set_mode;

  timekeeper_core #(.CLK_HZ(HZ), .INIT_HOUR(IH), .INIT_MIN(IM)) dut (
    .clk(clk), .reset(reset), .set(set), .op1(op1), .op2(op2),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .seconds(seconds), .minutes(minutes), .hours(hours), .hours12(hours12),
    .is_pm(is_pm), .set_mode(set_mode), .sec_tick(sec_tick), .day_wrap(day_wrap),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [3:0] h12;
    logic       pm;
    logic [1:0] mode;
    logic       st;
    logic       dw;
    logic       al;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time kept as seconds since midnight.
  int tod = IH * 3600 + IM * 60;
  int mode = 0, presc = 0;
  bit m_st = 0, m_dw = 0, m_al = 0;
  bit a_en = 0;
  int a_h = 0, a_m = 0;

  function automatic obs_t model_view();
    obs_t o;
    int h;
    h      = tod / 3600;
    o.s    = 6'(tod % 60);
    o.m    = 6'((tod / 60) % 60);
    o.h    = 5'(h);
    o.h12  = 4'(((h + 11) % 12) + 1);
    o.pm   = (h >= 12);
    o.mode = 2'(mode);
    o.st   = m_st;
    o.dw   = m_dw;
    o.al   = m_al;
    return o;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit o1, input bit o2, input bit ack);
    bit tick;
    int h, m, sc, d;
    if (r) begin
      tod = IH * 3600 + IM * 60; mode = 0; presc = 0; m_st = 0; m_dw = 0; m_al = 0;
      return;
    end
    tick  = (mode == 0) && (presc == HZ - 1);
    m_st  = tick;
    m_dw  = tick && (tod == DAY - 1);
    presc = (mode == 0 && !tick) ? presc + 1 : 0;
    if (tick) tod = (tod + 1) % DAY;
`ifdef TK_ALARM_EN
    if (ack || !a_en) m_al = 0;
    else if (tick && tod == a_h * 3600 + a_m * 60) m_al = 1;
`else
    m_al = 0;
`endif
    if (mode != 0 && !s && (o1 != o2)) begin
      h = tod / 3600; m = (tod / 60) % 60; sc = tod % 60;
      d = o1 ? 1 : -1;
      case (mode)
        1: h  = (h + d + 24) % 24;
        2: m  = (m + d + 60) % 60;
        default: sc = (sc + d + 60) % 60;
      endcase
      tod = h * 3600 + m * 60 + sc;
    end
    if (s) mode = (mode + 1) % 4;
  endtask

  task automatic step(input bit r, input bit s, input bit o1, input bit o2, input bit ack);
    @(negedge clk);
    reset = r; set = s; op1 = o1; op2 = o2; alarm_ack = ack;
    alarm_en = a_en; alarm_hours = 5'(a_h); alarm_minutes = 6'(a_m);
    model_edge(r, s, o1, o2, ack);
    exp_q.push_back(model_view());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic press(input bit s, input bit o1, input bit o2, input int n);
    for (int i = 0; i < n; i++) step(0, s, o1, o2, 0);
  endtask

  // Monitor: outputs are presented every cycle, so every posedge with a pending prediction is a transaction.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{s: seconds, m: minutes, h: hours, h12: hours12, pm: is_pm, mode: set_mode,
              st: sec_tick, dw: day_wrap, al: alarm};
        checks++;
        $display("txn %0d %0d:%0d:%0d h12=%0d pm=%0d mode=%0d tick=%0d wrap=%0d alarm=%0d",
                 checks, a.h, a.m, a.s, a.h12, a.pm, a.mode, a.st, a.dw, a.al);
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs got %0d:%0d:%0d h12=%0d pm=%0d mode=%0d st=%0d dw=%0d al=%0d expected %0d:%0d:%0d h12=%0d pm=%0d mode=%0d st=%0d dw=%0d al=%0d",
                   a.h, a.m, a.s, a.h12, a.pm, a.mode, a.st, a.dw, a.al,
                   e.h, e.m, e.s, e.h12, e.pm, e.mode, e.st, e.dw, e.al);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, release, first second after a full prescaler period
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    run(8);
    // 2: preload 23:59:59 and roll the day over
    press(1, 0, 0, 1); press(0, 0, 1, 1);
    press(1, 0, 0, 1); press(0, 0, 1, 1);
    press(1, 0, 0, 1); press(0, 0, 1, 3);
    press(1, 0, 0, 1);
    run(6);
    // 3: field wraps without carry
    press(1, 0, 0, 1); press(0, 0, 1, 1);
    press(1, 0, 0, 1); press(0, 0, 1, 1); press(0, 1, 0, 1);
    press(1, 0, 0, 2);
    run(2);
    // 4: simultaneous ops cancel; set beats op
    press(1, 0, 0, 2); press(0, 1, 1, 1); press(1, 1, 0, 1); press(1, 0, 0, 1);
    run(3);
    // 5: asynchronous reset in the middle of a SET_SEC cycle
    press(1, 0, 0, 3); press(0, 1, 0, 2);
    @(negedge clk);
    #2;
    reset = 1'b1; set = 1'b0; op1 = 1'b0; op2 = 1'b0;
    model_edge(1, 0, 0, 0, 0);
    exp_q.push_back(model_view());
    #1;
    checks++;
    if (hours !== 5'(IH) || minutes !== 6'(IM) || seconds !== 6'd0 || set_mode !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got %0d:%0d:%0d mode=%0d expected %0d:%0d:0 mode=0",
               hours, minutes, seconds, set_mode, IH, IM);
    end
    step(1, 0, 0, 0, 0);
    run(2);
    // 6: alarm at 07:30 from 07:29:59, then acknowledge
    a_en = 1; a_h = 7; a_m = 30;
    press(1, 0, 0, 1); press(0, 1, 0, 7);
    press(1, 0, 0, 1); press(0, 1, 0, 29);
    press(1, 0, 0, 1); press(0, 0, 1, 1);
    press(1, 0, 0, 1);
    run(6);
    step(0, 0, 0, 0, 1);
    run(3);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit rs, r1, r2, rk, rr;
      rs = ($urandom_range(15) == 0);
      r1 = ($urandom_range(3) == 0);
      r2 = ($urandom_range(3) == 0);
      rk = ($urandom_range(31) == 0);
      rr = ($urandom_range(255) == 0);
      if ($urandom_range(63) == 0) a_en = !a_en;
      if ($urandom_range(63) == 0) begin
        a_h = tod / 3600; a_m = ((tod / 60) + 1) % 60;
      end
      step(rr, rs, r1, r2, rk);
    end
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
